dmem_responder: RTL and testbench
=================================

# dmem_responder

Variable-latency data-memory responder that services load/store requests issued by the pipelined MIPS data path from its memory stage. It owns a word-organised RAM, applies byte-enables on stores, and inserts a programmable number of wait states. Like the multiplier, it reports `busy` so the hazard detector can stall the pipeline. `ready` pulses once per completed access, with load data or an error flag.

## Interface
Parameters:
- DEPTH, 256: number of 32-bit words in the backing RAM (power of two, 4..65536)
- LATENCY, 2: wait states inserted per valid access (0..15)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset)
- req  input  1  access request; sampled on each rising edge while accepting
- we  input  1  1 = store, 0 = load
- addr  input  32  byte address; must be word-aligned
- wdata  input  32  store data
- be  input  4  store byte enables; be[i] enables wdata[8i+7:8i]; ignored for loads
- busy  output  1  access in progress (WAIT state); hazard unit stalls on `req` in the issue cycle or `busy`
- ready  output  1  one-cycle completion pulse
- rdata  output  32  load data; valid while `ready` = 1 for a successful load
- err  output  1  qualifies `ready`: access rejected (misaligned or out of range)

## Operation
- FSM states are IDLE, WAIT and RESP. The block accepts a request when `req` = 1 on an edge while in IDLE or RESP.
- On acceptance, latch `we`, `addr`, `wdata` and `be`. Compute `bad` = (addr[1:0] != 0) or (addr[31:2] >= DEPTH).
  - If `bad`, go to RESP with err = 1.
  - Else if LATENCY = 0, go to RESP and perform the access on this edge.
  - Else go to WAIT and load the wait counter with LATENCY-1.
- In WAIT, decrement the counter each edge. When the counter is 0, perform the access and go to RESP. `req` is ignored in WAIT: no queuing, and no effect on the latched request.
- Performing the access:
  - Store: write each byte lane with be[i] = 1 into RAM[addr[31:2]]. With be = 0, the RAM is unchanged and the access completes normally.
  - Load: rdata <= RAM[addr[31:2]].
- RESP lasts one cycle with ready = 1. After RESP, go to IDLE, or accept a new request on that same edge.
- Output registers:
  - `rdata` updates only on successful loads. It holds its value on stores and on errors.
  - `err` is registered and is 1 only during RESP of a rejected access.
  - On a rejected access nothing is written.
- Decoded outputs: busy = (state == WAIT); ready = (state == RESP).
- RAM contents are not reset and are undefined until written.

## Timing
- Reset (reset = 0, asynchronous):
  - state goes to IDLE; busy, ready and err go to 0; rdata goes to 0.
  - The counter goes to 0.
  - Any pending store is discarded and no `ready` pulse is produced.
  - On release, the first edge with reset = 1 may accept a request.
- Valid access accepted at edge N:
  - busy = 1 for cycles N+1..N+LATENCY.
  - The RAM write or read occurs at edge N+LATENCY.
  - ready = 1 for exactly the cycle after edge N+LATENCY.
- Rejected access accepted at edge N: ready = err = 1 in the cycle after edge N, independent of LATENCY, and busy stays 0.
- Throughput: back-to-back requests accepted in RESP give one access every LATENCY+1 cycles.
- Read-after-write: a load accepted in the RESP cycle of a store to the same word returns the newly written bytes.
- Reset asserted while in WAIT or RESP: all outputs drop to 0 immediately (asynchronously), with no partial write.

## Test plan
- Reset, LATENCY=2: hold reset=0 for 3 cycles, then release. Store addr=0x10, wdata=0xDEADBEEF, be=4'hF at edge N, then load addr=0x10. Required:
  - busy=1 in cycles N+1 and N+2, ready in the cycle after edge N+2.
  - The load's ready pulse shows rdata=0xDEADBEEF, err=0.
- Byte enables: word 0x10 holds 0xDEADBEEF; store wdata=0x11223344, be=4'b0101, then load. Required: rdata=0xDE22BE44.
- Errors:
  - Load addr=0x12 (misaligned): ready=err=1 in the cycle after acceptance, busy never 1, rdata unchanged.
  - Store to addr=DEPTH*4: err=1 and the RAM is unchanged.
- Back-to-back, LATENCY=0: hold req=1 with 4 loads from addresses 0x0, 0x4, 0x8, 0xC, each presented on successive edges. Required: ready=1 for 4 consecutive cycles with the matching data, and busy=0 throughout.
- Reset mid-operation, LATENCY=5: store 0xCAFEF00D to 0x20 (previously 0x12345678). Assert reset in the second WAIT cycle. Required:
  - busy and ready drop to 0 immediately, and no ready pulse follows.
  - A later load of 0x20 returns 0x12345678.

Source files
------------

// File: rtl/dmem_responder.sv
// Variable-latency data-memory responder for the MIPS memory stage.
// A word-organised RAM with byte-lane write enables, programmable wait states and a registered response.
module dmemLane #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int VEC_W = 8
) (
  input  logic             clk,
  input  logic             wen,
  input  logic [AW-1:0]    idx,
  input  logic [VEC_W-1:0] wbyte,
  output logic [VEC_W-1:0] rbyte
);
  logic [VEC_W-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (wen) mem[idx] <= wbyte;

  assign rbyte = mem[idx];
endmodule

module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic        busy,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;
  localparam int AW        = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;

  stateT state, nextState;
  logic [3:0] cnt;
  logic       weQ, errQ;
  logic [AW-1:0] idxQ;
  logic [NUM_LANES-1:0][VEC_W-1:0] wdataQ;
  logic [NUM_LANES-1:0] beQ;
  logic [31:0] rdataQ;

  logic accept, bad, inWait, doAccess;
  logic accWe;
  logic [AW-1:0] accIdx;
  logic [NUM_LANES-1:0][VEC_W-1:0] accData, ramRd;
  logic [NUM_LANES-1:0] accBe, laneWen;

  assign bad    = (addr[1:0] != 2'b00) || (|addr[31:AW+2]);
  assign inWait = (state == WAIT);
  assign accept = req && !inWait;

  always_comb begin
    nextState = IDLE;
    doAccess  = 1'b0;
    if (accept) begin
      nextState = (bad || LATENCY == 0) ? RESP : WAIT;
      doAccess  = !bad && (LATENCY == 0);
    end else if (inWait) begin
      nextState = (cnt == 4'd0) ? RESP : WAIT;
      doAccess  = (cnt == 4'd0);
    end
  end

  // Zero-latency accesses hit the RAM on the accept edge, so they bypass the latches.
  assign accWe   = inWait ? weQ    : we;
  assign accIdx  = inWait ? idxQ   : addr[AW+1:2];
  assign accData = inWait ? wdataQ : wdata;
  assign accBe   = inWait ? beQ    : be;

  for (genvar i = 0; i < NUM_LANES; i++) begin : gLane
    assign laneWen[i] = doAccess && accWe && accBe[i];
    dmemLane #(.DEPTH(DEPTH), .AW(AW), .VEC_W(VEC_W)) uLane (
      .clk   (clk),
      .wen   (laneWen[i]),
      .idx   (accIdx),
      .wbyte (accData[i]),
      .rbyte (ramRd[i])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      weQ    <= 1'b0;
      idxQ   <= '0;
      wdataQ <= '0;
      beQ    <= '0;
      errQ   <= 1'b0;
      rdataQ <= 32'd0;
    end else begin
      state <= nextState;
      errQ  <= accept && bad;
      if (accept) begin
        weQ    <= we;
        idxQ   <= addr[AW+1:2];
        wdataQ <= wdata;
        beQ    <= be;
      end
      if (accept && !bad)
        cnt <= CNT_INIT;
      else if (inWait && cnt != 4'd0)
        cnt <= cnt - 4'd1;
      if (doAccess && !accWe)
        rdataQ <= ramRd;
    end
  end

  assign busy  = inWait;
  assign ready = (state == RESP);
  assign err   = errQ;
  assign rdata = rdataQ;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances at LATENCY 2, 0 and 5.
module tb_dmem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstN  [3];
  logic        req   [3];
  logic        we    [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [3:0]  be    [3];
  logic        busy  [3];
  logic        ready [3];
  logic [31:0] rdata [3];
  logic        err   [3];
  int lat [3] = '{2, 0, 5};

  int nTot = 0;
  int nBad = 0;

  dmem_responder #(.DEPTH(256), .LATENCY(2)) uDut2 (
    .clk(clk), .reset(rstN[0]), .req(req[0]), .we(we[0]), .addr(addr[0]),
    .wdata(wdata[0]), .be(be[0]), .busy(busy[0]), .ready(ready[0]),
    .rdata(rdata[0]), .err(err[0]));
  dmem_responder #(.DEPTH(256), .LATENCY(0)) uDut0 (
    .clk(clk), .reset(rstN[1]), .req(req[1]), .we(we[1]), .addr(addr[1]),
    .wdata(wdata[1]), .be(be[1]), .busy(busy[1]), .ready(ready[1]),
    .rdata(rdata[1]), .err(err[1]));
  dmem_responder #(.DEPTH(256), .LATENCY(5)) uDut5 (
    .clk(clk), .reset(rstN[2]), .req(req[2]), .we(we[2]), .addr(addr[2]),
    .wdata(wdata[2]), .be(be[2]), .busy(busy[2]), .ready(ready[2]),
    .rdata(rdata[2]), .err(err[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTot++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  task automatic chkIdle(input int d, input string tag);
    chk({tag, "/busy"},  32'(busy[d]),  32'd0);
    chk({tag, "/ready"}, 32'(ready[d]), 32'd0);
    chk({tag, "/err"},   32'(err[d]),   32'd0);
  endtask

  // Called at a negedge; returns at the negedge inside the RESP cycle.
  task automatic acc(input int d, input logic w, input logic [31:0] ad, input logic [31:0] wd,
                     input logic [3:0] b, input logic expErr, input logic [31:0] expRd,
                     input string tag);
    req[d] = 1'b1; we[d] = w; addr[d] = ad; wdata[d] = wd; be[d] = b;
    @(negedge clk);
    req[d] = 1'b0;
    if (!expErr)
      for (int i = 0; i < lat[d]; i++) begin
        chk({tag, "/busy"},  32'(busy[d]),  32'd1);
        chk({tag, "/rdyLo"}, 32'(ready[d]), 32'd0);
        @(negedge clk);
      end
    chk({tag, "/ready"}, 32'(ready[d]), 32'd1);
    chk({tag, "/err"},   32'(err[d]),   32'(expErr));
    chk({tag, "/busy0"}, 32'(busy[d]),  32'd0);
    if (!w) chk({tag, "/rdata"}, rdata[d], expRd);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rstN[d] = 1'b0; req[d] = 1'b0; we[d] = 1'b0;
      addr[d] = '0; wdata[d] = '0; be[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chkIdle(d, "rst");
      chk("rst/rdata", rdata[d], 32'd0);
      rstN[d] = 1'b1;
    end

    // LATENCY=2: store then read-after-write load issued in the store's RESP cycle
    acc(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, "st10");
    acc(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF, "ld10");
    acc(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, 1'b0, 32'h0, "stBe");
    acc(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDE22BE44, "ldBe");
    acc(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 1'b0, 32'h0, "stBe0");
    acc(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDE22BE44, "ldBe0");
    acc(0, 1'b0, 32'h12, 32'h0, 4'h0, 1'b1, 32'hDE22BE44, "ldMis");
    acc(0, 1'b1, 32'h0, 32'h55AA55AA, 4'hF, 1'b0, 32'h0, "st0");
    acc(0, 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0, "stOor");
    acc(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h55AA55AA, "ld0");
    acc(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDE22BE44, "ld10b");
    @(negedge clk);
    chkIdle(0, "idle2");

    // LATENCY=0: fill four words, then stream four loads back-to-back
    for (int i = 0; i < 4; i++)
      acc(1, 1'b1, 32'(4 * i), 32'hA0B0C000 + 32'(i), 4'hF, 1'b0, 32'h0, "stB");
    @(negedge clk);
    chkIdle(1, "idle0");
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("b2b/ready", 32'(ready[1]), 32'd1);
      chk("b2b/busy",  32'(busy[1]),  32'd0);
      chk("b2b/err",   32'(err[1]),   32'd0);
      chk("b2b/rdata", rdata[1], 32'hA0B0C000 + 32'(i));
      if (i < 3) addr[1] = 32'(4 * (i + 1));
      else       req[1]  = 1'b0;
    end
    @(negedge clk);
    chkIdle(1, "b2bEnd");

    // LATENCY=5: reset during the second WAIT cycle must abort the store
    acc(2, 1'b1, 32'h20, 32'h12345678, 4'hF, 1'b0, 32'h0, "st20");
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h20; wdata[2] = 32'hCAFEF00D; be[2] = 4'hF;
    @(negedge clk);
    req[2] = 1'b0;
    chk("mid/busy1", 32'(busy[2]), 32'd1);
    @(negedge clk);
    chk("mid/busy2", 32'(busy[2]), 32'd1);
    rstN[2] = 1'b0;
    #1;
    chkIdle(2, "midRst");
    repeat (2) @(negedge clk);
    rstN[2] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("noPulse", 32'(ready[2]), 32'd0);
    end
    acc(2, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 32'h12345678, "ld20");
    @(negedge clk);
    chkIdle(2, "idle5");

    $display("test done: total=%0d bad=%0d", nTot, nBad);
    $finish;
  end
endmodule
